e203_ifu_nxtpc: RTL and testbench

E203_IFU_NXTPC -- requirements
Module: e203_ifu_nxtpc

---
 rtl/e203_ifu_pkg.sv | 17 +
 rtl/e203_ifu_nxtpc_calc.sv | 31 +++
 rtl/e203_ifu_nxtpc_dff.sv | 22 ++
 rtl/e203_ifu_nxtpc.sv | 180 ++++++++++++++++++
 tb/tb_e203_ifu_nxtpc.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_ifu_pkg.sv
// Shared IFU definitions: FSM encodings, reset PC and PC increments.
// Used by the e203_ifu_nxtpc slice.
package e203_ifu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DFLT = 32'h8000_0000;

    localparam int INC_32 = 4;
    localparam int INC_16 = 2;

endpackage

// File: rtl/e203_ifu_nxtpc_calc.sv
// Combinational next-PC: predicted target or sequential increment.
// Compressed (+2) step is enabled by E203_IFU_NXTPC_RVC_EN.
module e203_ifu_nxtpc_calc
    import e203_ifu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic            is16,
    input  logic            taken,
    input  logic [PC_W-1:0] op1,
    input  logic [PC_W-1:0] op2,
    output logic [PC_W-1:0] nxt_pc
);

    logic [PC_W-1:0] inc;
    logic [PC_W-1:0] sum;

`ifdef E203_IFU_NXTPC_RVC_EN
    assign inc = is16 ? PC_W'(INC_16) : PC_W'(INC_32);
`else
    logic unused_is16;
    assign unused_is16 = is16;
    assign inc = PC_W'(INC_32);
`endif

    // Both sums wrap naturally at PC_W bits.
    assign sum    = taken ? (op1 + op2) : (pc + inc);
    assign nxt_pc = sum & ~PC_W'(1);

endmodule

// File: rtl/e203_ifu_nxtpc_dff.sv
// General DFF primitive: synchronous active-high reset, load enable.
// Reset value is a parameter so it serves state, PC and flag flops.
module e203_ifu_nxtpc_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/e203_ifu_nxtpc.sv
// IFU next-PC FSM: one outstanding fetch, BPU hold and flush drop.
// Optional compressed step via E203_IFU_NXTPC_RVC_EN.
module e203_ifu_nxtpc
    import e203_ifu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DFLT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [PC_W-1:0] ifu_req_pc,
    input  logic            ifu_rsp_valid,
    output logic            ifu_rsp_ready,
    input  logic            ifu_rsp_is16,
    output logic            ifu_o_valid,
    input  logic            ifu_o_ready,
    output logic [PC_W-1:0] ifu_o_pc,
    input  logic            bpu_wait,
    input  logic            prdt_taken,
    input  logic [PC_W-1:0] prdt_pc_add_op1,
    input  logic [PC_W-1:0] prdt_pc_add_op2,
    input  logic            pipe_flush_req,
    input  logic [PC_W-1:0] pipe_flush_pc,
    output logic            pipe_flush_ack
);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      state_raw;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            drop_q;
    logic            drop_d;
    logic [PC_W-1:0] nxt_pc;
    logic [PC_W-1:0] flush_pc;

    assign state_q  = state_t'(state_raw);
    assign flush_pc = pipe_flush_pc & ~PC_W'(1);

    e203_ifu_nxtpc_calc #(
        .PC_W(PC_W)
    ) u_calc (
        .pc    (pc_q),
        .is16  (ifu_rsp_is16),
        .taken (prdt_taken),
        .op1   (prdt_pc_add_op1),
        .op2   (prdt_pc_add_op2),
        .nxt_pc(nxt_pc)
    );

    e203_ifu_nxtpc_dff #(
        .W      (2),
        .RST_VAL(ST_BOOT)
    ) u_state_dff (
        .clk(clk),
        .rst(rst),
        .en (1'b1),
        .d  (state_d),
        .q  (state_raw)
    );

    e203_ifu_nxtpc_dff #(
        .W      (PC_W),
        .RST_VAL(RESET_PC)
    ) u_pc_dff (
        .clk(clk),
        .rst(rst),
        .en (1'b1),
        .d  (pc_d),
        .q  (pc_q)
    );

    e203_ifu_nxtpc_dff #(
        .W      (1),
        .RST_VAL(1'b0)
    ) u_drop_dff (
        .clk(clk),
        .rst(rst),
        .en (1'b1),
        .d  (drop_d),
        .q  (drop_q)
    );

    assign ifu_req_pc = pc_q;
    assign ifu_o_pc   = pc_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drop_d         = drop_q;
        ifu_req_valid  = 1'b0;
        ifu_rsp_ready  = 1'b0;
        ifu_o_valid    = 1'b0;
        pipe_flush_ack = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                pc_d    = RESET_PC;
            end
            ST_REQ: begin
                ifu_req_valid  = 1'b1;
                pipe_flush_ack = pipe_flush_req;
                if (pipe_flush_req) begin
                    pc_d = flush_pc;
                    // Request accepted under flush: its response is stale.
                    if (ifu_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (ifu_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pipe_flush_ack = pipe_flush_req;
                ifu_o_valid    = ifu_rsp_valid & ~drop_q;
                if (drop_q) begin
                    ifu_rsp_ready = 1'b1;
                    if (pipe_flush_req) begin
                        pc_d = flush_pc;
                    end
                    if (ifu_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end
                end else if (pipe_flush_req) begin
                    pc_d = flush_pc;
                    if (ifu_rsp_valid) begin
                        ifu_rsp_ready = 1'b1;
                        state_d       = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (ifu_o_valid && bpu_wait) begin
                    state_d = ST_HOLD;
                end else if (ifu_o_valid && ifu_o_ready) begin
                    ifu_rsp_ready = 1'b1;
                    pc_d          = nxt_pc;
                    state_d       = ST_REQ;
                end
            end
            ST_HOLD: begin
                pipe_flush_ack = pipe_flush_req;
                ifu_o_valid    = ifu_rsp_valid;
                if (pipe_flush_req) begin
                    pc_d = flush_pc;
                    if (ifu_rsp_valid) begin
                        ifu_rsp_ready = 1'b1;
                        state_d       = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (!bpu_wait) begin
                    if (ifu_o_valid && ifu_o_ready) begin
                        ifu_rsp_ready = 1'b1;
                        pc_d          = nxt_pc;
                        state_d       = ST_REQ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (rst) begin
            ifu_req_valid  = 1'b0;
            ifu_rsp_ready  = 1'b0;
            ifu_o_valid    = 1'b0;
            pipe_flush_ack = 1'b0;
        end
    end

endmodule

// File: tb/tb_e203_ifu_nxtpc.sv
// Directed self-checking bench for e203_ifu_nxtpc.
// Compressed-step checks follow E203_IFU_NXTPC_RVC_EN.
module tb_e203_ifu_nxtpc;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic        ifu_rsp_is16;
    logic        ifu_o_valid;
    logic        ifu_o_ready;
    logic [31:0] ifu_o_pc;
    logic        bpu_wait;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1;
    logic [31:0] prdt_pc_add_op2;
    logic        pipe_flush_req;
    logic [31:0] pipe_flush_pc;
    logic        pipe_flush_ack;

    int passed = 0;
    int total  = 0;

    e203_ifu_nxtpc dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_is16   (ifu_rsp_is16),
        .ifu_o_valid    (ifu_o_valid),
        .ifu_o_ready    (ifu_o_ready),
        .ifu_o_pc       (ifu_o_pc),
        .bpu_wait       (bpu_wait),
        .prdt_taken     (prdt_taken),
        .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2),
        .pipe_flush_req (pipe_flush_req),
        .pipe_flush_pc  (pipe_flush_pc),
        .pipe_flush_ack (pipe_flush_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifu_req_ready   = 1'b0;
        ifu_rsp_valid   = 1'b0;
        ifu_rsp_is16    = 1'b0;
        ifu_o_ready     = 1'b0;
        bpu_wait        = 1'b0;
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = '0;
        prdt_pc_add_op2 = '0;
        pipe_flush_req  = 1'b0;
        pipe_flush_pc   = '0;
    endtask

    // Issue request (state REQ) and advance into WAIT.
    task automatic issue();
        idle();
        ifu_req_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst            = 1'b1;
        pipe_flush_req = 1'b1;
        ifu_rsp_valid  = 1'b1;
        cyc();
        cyc();
        #1;
        total++;
        if ({ifu_req_valid, ifu_rsp_ready, ifu_o_valid, pipe_flush_ack} !== 4'b0)
            $display("FAIL reset_outs got %b want 0000",
                     {ifu_req_valid, ifu_rsp_ready, ifu_o_valid, pipe_flush_ack});
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({ifu_req_valid, ifu_rsp_ready, ifu_o_valid, pipe_flush_ack} !== 4'b0)
            $display("FAIL boot_outs got %b want 0000",
                     {ifu_req_valid, ifu_rsp_ready, ifu_o_valid, pipe_flush_ack});
        else passed++;
        cyc();
        idle();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            idle();
            ifu_req_ready = 1'b1;
            #1;
            total++;
            if (!ifu_req_valid || ifu_req_pc !== exp_pc)
                $display("FAIL seq_req%0d got v=%b pc=%h want v=1 pc=%h",
                         i, ifu_req_valid, ifu_req_pc, exp_pc);
            else passed++;
            cyc();
            idle();
            ifu_rsp_valid = 1'b1;
            ifu_o_ready   = 1'b1;
            #1;
            total++;
            if ({ifu_o_valid, ifu_rsp_ready, ifu_req_valid} !== 3'b110 ||
                ifu_o_pc !== exp_pc)
                $display("FAIL seq_rsp%0d got ov/rr/qv=%b opc=%h want 110 opc=%h",
                         i, {ifu_o_valid, ifu_rsp_ready, ifu_req_valid},
                         ifu_o_pc, exp_pc);
            else passed++;
            cyc();
            exp_pc = exp_pc + 32'd4;
        end
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h8000_000C)
            $display("FAIL seq_last got v=%b pc=%h want v=1 pc=8000000c",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    task automatic test_taken();
        issue();
        ifu_rsp_valid   = 1'b1;
        ifu_o_ready     = 1'b1;
        prdt_taken      = 1'b1;
        prdt_pc_add_op1 = 32'h8000_0010;
        prdt_pc_add_op2 = 32'hFFFF_FFF0;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h8000_0000)
            $display("FAIL taken_wrap got v=%b pc=%h want v=1 pc=80000000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
        issue();
        ifu_rsp_valid   = 1'b1;
        ifu_o_ready     = 1'b1;
        prdt_taken      = 1'b1;
        prdt_pc_add_op1 = 32'h0000_0101;
        prdt_pc_add_op2 = 32'h0000_0100;
        cyc();
        idle();
        #1;
        total++;
        if (ifu_req_pc !== 32'h0000_0200)
            $display("FAIL taken_bit0 got pc=%h want 00000200", ifu_req_pc);
        else passed++;
    endtask

    task automatic test_bpu_wait();
        issue();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        bpu_wait      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({ifu_o_valid, ifu_rsp_ready, ifu_req_valid} !== 3'b100)
                $display("FAIL bpu_hold%0d got ov/rr/qv=%b want 100",
                         i, {ifu_o_valid, ifu_rsp_ready, ifu_req_valid});
            else passed++;
            cyc();
        end
        bpu_wait = 1'b0;
        #1;
        total++;
        if ({ifu_o_valid, ifu_rsp_ready, ifu_req_valid} !== 3'b110)
            $display("FAIL bpu_release got ov/rr/qv=%b want 110",
                     {ifu_o_valid, ifu_rsp_ready, ifu_req_valid});
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h0000_0204)
            $display("FAIL bpu_next got v=%b pc=%h want v=1 pc=00000204",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    task automatic test_flush_wait();
        issue();
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_1000;
        #1;
        total++;
        if (pipe_flush_ack !== 1'b1 || ifu_o_valid !== 1'b0)
            $display("FAIL fw_ack got ack=%b ov=%b want ack=1 ov=0",
                     pipe_flush_ack, ifu_o_valid);
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if ({ifu_req_valid, ifu_rsp_ready} !== 2'b01)
            $display("FAIL fw_drop_idle got qv/rr=%b want 01",
                     {ifu_req_valid, ifu_rsp_ready});
        else passed++;
        cyc();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        #1;
        total++;
        if ({ifu_o_valid, ifu_rsp_ready} !== 2'b01)
            $display("FAIL fw_drop_rsp got ov/rr=%b want 01",
                     {ifu_o_valid, ifu_rsp_ready});
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h0000_1000)
            $display("FAIL fw_next got v=%b pc=%h want v=1 pc=00001000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    task automatic test_flush_bpu();
        issue();
        ifu_rsp_valid  = 1'b1;
        ifu_o_ready    = 1'b1;
        bpu_wait       = 1'b1;
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_2000;
        #1;
        total++;
        if (pipe_flush_ack !== 1'b1)
            $display("FAIL fb_ack got %b want 1", pipe_flush_ack);
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h0000_2000)
            $display("FAIL fb_next got v=%b pc=%h want v=1 pc=00002000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    task automatic test_flush_req();
        ifu_req_ready  = 1'b1;
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_3000;
        #1;
        total++;
        if (pipe_flush_ack !== 1'b1 || ifu_req_valid !== 1'b1)
            $display("FAIL fr_ack got ack=%b qv=%b want 1 1",
                     pipe_flush_ack, ifu_req_valid);
        else passed++;
        cyc();
        idle();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        #1;
        total++;
        if ({ifu_o_valid, ifu_rsp_ready} !== 2'b01)
            $display("FAIL fr_drop got ov/rr=%b want 01",
                     {ifu_o_valid, ifu_rsp_ready});
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h0000_3000)
            $display("FAIL fr_next got v=%b pc=%h want v=1 pc=00003000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_4001;
        cyc();
        idle();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h0000_4000)
            $display("FAIL fr_idle got v=%b pc=%h want v=1 pc=00004000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    task automatic test_rvc();
`ifdef E203_IFU_NXTPC_RVC_EN
        issue();
        ifu_rsp_valid   = 1'b1;
        ifu_o_ready     = 1'b1;
        prdt_taken      = 1'b1;
        prdt_pc_add_op1 = 32'h8000_0002;
        cyc();
        issue();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        ifu_rsp_is16  = 1'b1;
        cyc();
        idle();
        #1;
        total++;
        if (ifu_req_pc !== 32'h8000_0004)
            $display("FAIL rvc_inc2 got pc=%h want 80000004", ifu_req_pc);
        else passed++;
        issue();
        ifu_rsp_valid   = 1'b1;
        ifu_o_ready     = 1'b1;
        prdt_taken      = 1'b1;
        prdt_pc_add_op1 = 32'hFFFF_FFFE;
        prdt_pc_add_op2 = 32'h0000_0004;
        cyc();
        idle();
        #1;
        total++;
        if (ifu_req_pc !== 32'h0000_0002)
            $display("FAIL rvc_wrap got pc=%h want 00000002", ifu_req_pc);
        else passed++;
`else
        issue();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        ifu_rsp_is16  = 1'b1;
        cyc();
        idle();
        #1;
        total++;
        if (ifu_req_pc !== 32'h0000_4004)
            $display("FAIL is16_ignored got pc=%h want 00004004", ifu_req_pc);
        else passed++;
`endif
    endtask

    task automatic test_reset_midwait();
        issue();
        ifu_rsp_valid = 1'b1;
        ifu_o_ready   = 1'b1;
        rst           = 1'b1;
        #1;
        total++;
        if ({ifu_o_valid, ifu_rsp_ready} !== 2'b00)
            $display("FAIL rmw_outs got ov/rr=%b want 00",
                     {ifu_o_valid, ifu_rsp_ready});
        else passed++;
        cyc();
        rst = 1'b0;
        idle();
        cyc();
        #1;
        total++;
        if (!ifu_req_valid || ifu_req_pc !== 32'h8000_0000)
            $display("FAIL rmw_restart got v=%b pc=%h want v=1 pc=80000000",
                     ifu_req_valid, ifu_req_pc);
        else passed++;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_taken();
        test_bpu_wait();
        test_flush_wait();
        test_flush_bpu();
        test_flush_req();
        test_rvc();
        test_reset_midwait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
